// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue controller: opcodes, shift controls,
// instruction field positions and controller state encoding.
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_MUL = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_XOR = 4'd5;

   localparam logic [2:0] SR_NONE = 3'd0;
   localparam logic [2:0] SR_SHR  = 3'd1;
   localparam logic [2:0] SR_SHL  = 3'd2;

   localparam int NREG   = 8;
   localparam int REG_AW = 3;

   localparam int OPC_MSB     = 31;
   localparam int OPC_LSB     = 28;
   localparam int SRC_MSB     = 27;
   localparam int SRC_LSB     = 25;
   localparam int SRB_MSB     = 24;
   localparam int SRB_LSB     = 20;
   localparam int RD_MSB      = 19;
   localparam int RD_LSB      = 17;
   localparam int RS1_MSB     = 16;
   localparam int RS1_LSB     = 14;
   localparam int RS2_MSB     = 13;
   localparam int RS2_LSB     = 11;
   localparam int IMM_SEL_BIT = 10;
   localparam int IMM_MSB     = 9;
   localparam int IMM_LSB     = 0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DRIVE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_RESP    = 2'd3
   } state_e;

   // Any shift control ignores the opcode; without a shift only the six ALU ops exist.
   function automatic logic instr_legal(input logic [3:0] opc, input logic [2:0] src);
      logic ok;
      ok = 1'b0;
      case (src)
         SR_NONE: begin
            case (opc)
               OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR: ok = 1'b1;
               default: ok = 1'b0;
            endcase
         end
         SR_SHR, SR_SHL: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8x32 register file: two asynchronous read ports, write-back and preload
// write sources resolved per entry with write-back taking priority.
module alu_regfile
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] ra_addr,
   input  logic [REG_AW-1:0] rb_addr,
   output logic [31:0]       ra_data,
   output logic [31:0]       rb_data,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [31:0]       wb_data,
   input  logic              ld_en,
   input  logic [REG_AW-1:0] ld_addr,
   input  logic [31:0]       ld_data
);

   logic [NREG-1:0][31:0] regs_q;
   logic [NREG-1:0][31:0] regs_d;

   // Preload and write-back may target different entries in the same cycle; both land.
   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_entry
         logic wb_hit;
         logic ld_hit;
         assign wb_hit     = wb_en && (wb_addr == REG_AW'(gi));
         assign ld_hit     = ld_en && (ld_addr == REG_AW'(gi));
         assign regs_d[gi] = wb_hit ? wb_data : (ld_hit ? ld_data : regs_q[gi]);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   assign ra_data = regs_q[ra_addr];
   assign rb_data = regs_q[rb_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue controller around an external combinational ALU: accept an
// instruction, hold registered ALU inputs for ALU_LAT cycles, capture, respond.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int ALU_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [31:0]       instr,
   input  logic              ld_en,
   input  logic [REG_AW-1:0] ld_addr,
   input  logic [31:0]       ld_data,
   output logic [31:0]       alu_In1,
   output logic [31:0]       alu_In2,
   output logic [3:0]        alu_opcode,
   output logic [4:0]        alu_SR_Bit,
   output logic [2:0]        alu_SR_Cont,
   input  logic [31:0]       alu_Out,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [31:0]       res_data,
   output logic [REG_AW-1:0] res_rd,
   output logic              res_err
);

   state_e            state_q, state_d;
   logic [1:0]        lat_cnt_q, lat_cnt_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic              illegal_q, illegal_d;
   logic [31:0]       alu_in1_q, alu_in1_d;
   logic [31:0]       alu_in2_q, alu_in2_d;
   logic [3:0]        alu_opcode_q, alu_opcode_d;
   logic [4:0]        alu_sr_bit_q, alu_sr_bit_d;
   logic [2:0]        alu_sr_cont_q, alu_sr_cont_d;
   logic [31:0]       res_data_q, res_data_d;
   logic [REG_AW-1:0] res_rd_q, res_rd_d;
   logic              res_err_q, res_err_d;

   logic [3:0]        f_opc;
   logic [2:0]        f_src;
   logic [4:0]        f_srb;
   logic [REG_AW-1:0] f_rd, f_rs1, f_rs2;
   logic              f_imm_sel;
   logic [9:0]        f_imm;
   logic [31:0]       rs1_data, rs2_data;
   logic              wb_en;
   logic              f_illegal;

   assign f_opc     = instr[OPC_MSB:OPC_LSB];
   assign f_src     = instr[SRC_MSB:SRC_LSB];
   assign f_srb     = instr[SRB_MSB:SRB_LSB];
   assign f_rd      = instr[RD_MSB:RD_LSB];
   assign f_rs1     = instr[RS1_MSB:RS1_LSB];
   assign f_rs2     = instr[RS2_MSB:RS2_LSB];
   assign f_imm_sel = instr[IMM_SEL_BIT];
   assign f_imm     = instr[IMM_MSB:IMM_LSB];
   assign f_illegal = !instr_legal(f_opc, f_src);

   assign wb_en = (state_q == ST_CAPTURE) && !illegal_q;

   alu_regfile u_regfile (
      .clk     (clk),
      .rst     (rst),
      .ra_addr (f_rs1),
      .rb_addr (f_rs2),
      .ra_data (rs1_data),
      .rb_data (rs2_data),
      .wb_en   (wb_en),
      .wb_addr (rd_q),
      .wb_data (alu_Out),
      .ld_en   (ld_en),
      .ld_addr (ld_addr),
      .ld_data (ld_data)
   );

   always_comb begin
      state_d       = state_q;
      lat_cnt_d     = lat_cnt_q;
      rd_d          = rd_q;
      illegal_d     = illegal_q;
      alu_in1_d     = alu_in1_q;
      alu_in2_d     = alu_in2_q;
      alu_opcode_d  = alu_opcode_q;
      alu_sr_bit_d  = alu_sr_bit_q;
      alu_sr_cont_d = alu_sr_cont_q;
      res_data_d    = res_data_q;
      res_rd_d      = res_rd_q;
      res_err_d     = res_err_q;

      case (state_q)
         ST_IDLE: begin
            if (instr_valid) begin
               state_d       = ST_DRIVE;
               lat_cnt_d     = 2'(ALU_LAT - 1);
               rd_d          = f_rd;
               illegal_d     = f_illegal;
               alu_in1_d     = rs1_data;
               alu_in2_d     = f_imm_sel ? {22'd0, f_imm} : rs2_data;
               // An illegal word still runs the sequence but drives a neutral ALU op.
               alu_opcode_d  = f_illegal ? 4'd0 : f_opc;
               alu_sr_cont_d = f_illegal ? 3'd0 : f_src;
               alu_sr_bit_d  = f_srb;
            end
         end
         ST_DRIVE: begin
            if (lat_cnt_q == 2'd0) begin
               state_d = ST_CAPTURE;
            end else begin
               lat_cnt_d = lat_cnt_q - 2'd1;
            end
         end
         ST_CAPTURE: begin
            state_d    = ST_RESP;
            res_data_d = illegal_q ? 32'd0 : alu_Out;
            res_rd_d   = rd_q;
            res_err_d  = illegal_q;
         end
         ST_RESP: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         lat_cnt_q     <= '0;
         rd_q          <= '0;
         illegal_q     <= 1'b0;
         alu_in1_q     <= '0;
         alu_in2_q     <= '0;
         alu_opcode_q  <= '0;
         alu_sr_bit_q  <= '0;
         alu_sr_cont_q <= '0;
         res_data_q    <= '0;
         res_rd_q      <= '0;
         res_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         lat_cnt_q     <= lat_cnt_d;
         rd_q          <= rd_d;
         illegal_q     <= illegal_d;
         alu_in1_q     <= alu_in1_d;
         alu_in2_q     <= alu_in2_d;
         alu_opcode_q  <= alu_opcode_d;
         alu_sr_bit_q  <= alu_sr_bit_d;
         alu_sr_cont_q <= alu_sr_cont_d;
         res_data_q    <= res_data_d;
         res_rd_q      <= res_rd_d;
         res_err_q     <= res_err_d;
      end
   end

   assign instr_ready = (state_q == ST_IDLE);
   assign res_valid   = (state_q == ST_RESP);
   assign alu_In1     = alu_in1_q;
   assign alu_In2     = alu_in2_q;
   assign alu_opcode  = alu_opcode_q;
   assign alu_SR_Bit  = alu_sr_bit_q;
   assign alu_SR_Cont = alu_sr_cont_q;
   assign res_data    = res_data_q;
   assign res_rd      = res_rd_q;
   assign res_err     = res_err_q;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequential issue controller that drives the existing combinational ALU (add/sub/mul/or/and/xor plus shift unit). It accepts 32-bit instruction words over a valid/ready handshake and reads operands from an internal 8x32 register file. It drives the ALU operand/opcode/shift ports, waits a fixed number of cycles, captures the ALU result and writes it back. The result is then presented on a valid/ready response port. It sits between the instruction source (bench or future fetch stage) and the ALU.

Parameters:
ALU_LAT, 1, cycles between driving ALU inputs and sampling alu_Out (legal range 1..4)
NREG, 8, register file depth (fixed at 8; index width 3)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
instr_valid  in  1  instruction word valid
instr_ready  out  1  controller can accept instruction
instr  in  32  [31:28] opcode, [27:25] sr_cont, [24:20] sr_bit, [19:17] rd, [16:14] rs1, [13:11] rs2, [10] imm_sel, [9:0] imm
ld_en  in  1  direct register-file write (preload)
ld_addr  in  3  preload index
ld_data  in  32  preload data
alu_In1  out  32  ALU operand 1 (= R[rs1])
alu_In2  out  32  ALU operand 2 (= imm_sel ? zero-extended imm : R[rs2])
alu_opcode  out  4  ALU opcode
alu_SR_Bit  out  5  ALU shift amount
alu_SR_Cont  out  3  ALU shift control
alu_Out  in  32  ALU result
res_valid  out  1  result valid
res_ready  in  1  consumer accepts result
res_data  out  32  captured result
res_rd  out  3  destination index of the result
res_err  out  1  illegal instruction flag, qualified by res_valid

Behaviour:
- Shared encodings: opcode 0000 ADD, 0001 SUB, 0010 MUL, 0011 OR, 0100 AND, 0101 XOR. sr_cont 000 NONE, 001 SHR (alu_Out = In2 >> SR_Bit), 010 SHL.
- Illegal instruction: sr_cont in 011..111, or sr_cont = 000 with opcode > 0101.
- FSM states and transitions:
  - IDLE -> DRIVE on instr_valid && instr_ready.
  - DRIVE -> CAPTURE after ALU_LAT cycles.
  - CAPTURE -> RESP after 1 cycle.
  - RESP -> IDLE on res_valid && res_ready.
- instr_ready = 1 only in IDLE; not combinationally dependent on instr_valid.
- On accept (cycle T): latch the instruction and read operands from the register file. alu_* outputs are registered and stable from T+1 until leaving CAPTURE.
- CAPTURE samples alu_Out at the end of cycle T+ALU_LAT+1. Register-file write-back of R[rd] happens on that edge unless the instruction is illegal.
- res_valid rises at T+ALU_LAT+2 (T+3 for default) and holds, with res_data, res_rd and res_err, stable until the handshake completes.
- Illegal instruction: still runs the full sequence. alu_opcode and alu_SR_Cont are forced to 0; res_err = 1; res_data = 0; no write-back.
- Preload (ld_en): accepted in any state.
  - If ld_en hits the same index as the CAPTURE write-back in the same cycle, write-back wins.
  - A preload to rs1/rs2 after the accept cycle does not affect the in-flight operands, which are already latched.
- Arithmetic: all results are 32-bit, modulo 2^32. MUL keeps the low 32 bits and SUB wraps. Results are taken from alu_Out as-is; there is no internal recomputation.
- Only one instruction is in flight; no hazards exist. Back-to-back throughput is one instruction per ALU_LAT+3 cycles with res_ready held high.
- Reset, including mid-operation:
  - State goes to IDLE and all 8 registers clear to 0.
  - All outputs are 0 (alu_*, res_*), except instr_ready, which is 1 in the cycle after reset deasserts.
  - An in-flight instruction is dropped silently.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_ADD..OP_XOR)
  - sr_cont localparams (SR_NONE, SR_SHR, SR_SHL)
  - instruction field bit positions
  - FSM state encoding (2-bit)
- One sub-module, alu_regfile: 8x32, two async read ports, one sync write port with a priority mux for write-back over ld. It is reset to 0 synchronously.

Test Plan:
- Preload R1=15, R2=20. Issue ADD rd=3 rs1=1 rs2=2 -> alu_In1=15 and alu_In2=20 at T+1; res_valid at T+3 with res_data=35, res_rd=3, res_err=0; R3 reads back 35.
- Issue SUB rs1=R1=10, imm_sel=1, imm=30 -> res_data=0xFFFFFFEC (wrap). Then MUL with R1=0x10000, R2=0x10000 -> res_data=0.
- Issue SHR: sr_cont=001, sr_bit=4, rs2 holds 0x12345678 -> alu_SR_Cont=001, res_data=0x01234567. Repeat with SHL -> res_data=0x23456780.
- Issue opcode 0111 with sr_cont=000, then sr_cont=101 -> res_err=1 and res_data=0 both times; rd contents unchanged.
- Hold res_ready=0 for 5 cycles -> res_valid and res_data stable and instr_ready=0 throughout; on release, IDLE follows the next cycle. Assert ld_en to rd in the CAPTURE cycle -> the ALU result is stored.
- Assert rst during DRIVE -> next cycle all outputs are 0, instr_ready=1, registers read 0, and no res_valid appears afterwards.
